seg7_scanner: RTL and testbench

SEG7_SCANNER -- requirements
Module: seg7_scanner

---
 rtl/seg7_scanner.sv | 173 +++++++++++++++++
 tb/tb_seg7_scanner.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scanner.sv
// Multiplexed 7-segment scanner with double-buffered digit registers.
// Optional leading-zero suppression: define SEG7_LZ_SUPPRESS_EN.
module seg7_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_tick
);
    localparam int PW = $clog2(DIV_COUNT);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [IW-1:0]           index_q, index_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    boundary_q, boundary_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    tc, wrap, in_blank;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_mask, cur_supp;
    logic [NUM_DIGITS-1:0]   cur_an;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz_supp;

    // Walk down from the most significant digit while nibbles stay zero.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_supp = '0;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            run        = run && (disp_val_q[4*k +: 4] == 4'h0);
            lz_supp[k] = run;
        end
    end
`endif

    always_comb begin
        tc          = (prescaler_q == PW'(DIV_COUNT - 1));
        wrap        = tc && (index_q == IW'(NUM_DIGITS - 1));
        prescaler_d = tc ? '0 : prescaler_q + PW'(1);
        index_d     = index_q;
        if (tc) begin
            index_d = (index_q == IW'(NUM_DIGITS - 1)) ? '0 : index_q + IW'(1);
        end
        boundary_d   = wrap;
        frame_tick_d = boundary_q;
    end

    // A load landing on the boundary goes straight to the display and leaves pending clear.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp;
            pending_d    = 1'b1;
        end
        if (wrap) begin
            pending_d = 1'b0;
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
        end
    end

    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_mask = 1'b1;
        cur_supp = 1'b0;
        cur_an   = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == index_q) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_mask  = blank_mask[k];
                cur_an[k] = 1'b0;
`ifdef SEG7_LZ_SUPPRESS_EN
                cur_supp  = lz_supp[k];
`endif
            end
        end
    end

    always_comb begin
        in_blank = (int'(prescaler_q) < BLANK_CYCLES);
        an_d     = '1;
        seg_d    = 8'hFF;
        if (!in_blank) begin
            if (!cur_mask) begin
                an_d = cur_an;
            end
            seg_d = {~cur_dp, cur_supp ? 7'h7F : hex7(cur_nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q  <= '0;
            index_q      <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            boundary_q   <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            index_q      <= index_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            boundary_q   <= boundary_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner (NUM_DIGITS=4, DIV_COUNT=4, BLANK_CYCLES=1).
// Honours SEG7_LZ_SUPPRESS_EN when defined for the build.
module tb_seg7_scanner;
    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int BLK   = 1;
    localparam int FRAME = ND * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    seg7_scanner #(
        .NUM_DIGITS  (ND),
        .DIV_COUNT   (DIV),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .dp        (dp),
        .blank_mask(blank_mask),
        .an        (an),
        .seg       (seg),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: m counts rising edges since reset release; slot and
    // digit follow from m arithmetically.
    int          m;
    logic [15:0] sh_v, dsp_v;
    logic [3:0]  sh_dp, dsp_dp;
    logic        pend;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_ft;
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG7_LZ_SUPPRESS_EN
    localparam logic [7:0] LEAD_ZERO_SEG = 8'hFF;
`else
    localparam logic [7:0] LEAD_ZERO_SEG = 8'hC0;
`endif

    function automatic int cur_digit();
        return ((m - 1) / DIV) % ND;
    endfunction

    function automatic int cur_phase();
        return (m - 1) % DIV;
    endfunction

    task automatic model_reset();
        m = 0; sh_v = '0; dsp_v = '0; sh_dp = '0; dsp_dp = '0; pend = 1'b0;
    endtask

    // Predicts the outputs of the coming edge, takes it, then applies the load/boundary rules.
    task automatic step();
        int p, d;
        logic [3:0] nib;
        logic lz;
        p = m % DIV;
        d = (m / DIV) % ND;
        exp_ft  = (m >= FRAME) && (m % FRAME == 0);
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
        if (p >= BLK) begin
            nib = dsp_v[4*d +: 4];
            if (!blank_mask[d]) exp_an = ~(4'b0001 << d);
            exp_seg = {~dsp_dp[d], hex_tab[nib]};
            lz = (d > 0);
            for (int k = d; k < ND; k++) if (dsp_v[4*k +: 4] != 4'h0) lz = 1'b0;
`ifdef SEG7_LZ_SUPPRESS_EN
            if (lz) exp_seg[6:0] = 7'h7F;
`endif
        end
        @(posedge clk);
        if ((m + 1) % FRAME == 0) begin
            if (load) begin
                dsp_v = value; dsp_dp = dp; sh_v = value; sh_dp = dp;
            end else if (pend) begin
                dsp_v = sh_v; dsp_dp = sh_dp;
            end
            pend = 1'b0;
        end else if (load) begin
            sh_v = value; sh_dp = dp; pend = 1'b1;
        end
        m++;
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg, frame_tick} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL reset_initial an=%b seg=%h ft=%b expected 1111/ff/0", an, seg, frame_tick);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({an, seg, frame_tick} !== {4'hF, 8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL reset_hold an=%b seg=%h ft=%b expected 1111/ff/0", an, seg, frame_tick);
            end
        end
        rst_n = 1'b1;
        value = 16'h1234; dp = 4'b1010; load = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL reset_run m=%0d an=%b seg=%h ft=%b expected an=%b seg=%h ft=%b",
                         m, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg, frame_tick} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL reset_async an=%b seg=%h ft=%b expected 1111/ff/0", an, seg, frame_tick);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        dp = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL reset_resume m=%0d an=%b seg=%h ft=%b expected an=%b seg=%h ft=%b",
                         m, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
        end
        checks++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
            failures++;
            $display("FAIL reset_discard an=%b seg=%h expected 1110/c0", an, seg);
        end
    endtask

    task automatic test_load_scan();
        logic found;
        value = 16'h1234; dp = 4'b0000; load = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL scan_model m=%0d an=%b seg=%h ft=%b expected an=%b seg=%h ft=%b",
                         m, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (frame_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL scan_frame_wait frame_tick=%b expected a pulse within 40 cycles", frame_tick);
        end
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) step();
            if (cur_phase() == 0) begin
                checks++;
                if (an !== 4'hF) begin
                    failures++;
                    $display("FAIL scan_blank m=%0d an=%b expected 1111", m, an);
                end
            end else if (cur_digit() == 0) begin
                checks++;
                if (an !== 4'b1110 || seg !== 8'h99) begin
                    failures++;
                    $display("FAIL scan_d0 m=%0d an=%b seg=%h expected 1110/99", m, an, seg);
                end
            end else if (cur_digit() == 3) begin
                checks++;
                if (an !== 4'b0111 || seg !== 8'hF9) begin
                    failures++;
                    $display("FAIL scan_d3 m=%0d an=%b seg=%h expected 0111/f9", m, an, seg);
                end
            end
        end
    endtask

    task automatic test_tearing();
        int guard;
        guard = 0;
        while (!(cur_digit() == 1 && cur_phase() == 1) && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL tear_sync digit=%0d phase=%0d expected digit 1 phase 1", cur_digit(), cur_phase());
        end
        value = 16'hABCD; load = 1'b1;
        guard = 0;
        do begin
            step();
            guard++;
            if (cur_digit() == 2 && cur_phase() >= BLK) begin
                checks++;
                if (seg !== 8'hA4) begin
                    failures++;
                    $display("FAIL tear_d2 m=%0d seg=%h expected a4", m, seg);
                end
            end
        end while (frame_tick !== 1'b1 && guard < 40);
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL tear_frame_wait frame_tick=%b expected 1", frame_tick);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (an !== 4'b1110 || seg !== 8'hA1) begin
                failures++;
                $display("FAIL tear_d0 m=%0d an=%b seg=%h expected 1110/a1", m, an, seg);
            end
        end
    endtask

    task automatic test_mask_dp();
        value = 16'h5678; dp = 4'b0001; load = 1'b1;
        blank_mask = 4'b0100;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL mask_model m=%0d an=%b seg=%h ft=%b expected an=%b seg=%h ft=%b",
                         m, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            checks++;
            if (an[2] !== 1'b1) begin
                failures++;
                $display("FAIL mask_an2 m=%0d an=%b expected an[2]=1", m, an);
            end
            if (i >= FRAME && cur_digit() == 0 && cur_phase() >= BLK) begin
                checks++;
                if (seg !== 8'h00) begin
                    failures++;
                    $display("FAIL dp_d0 m=%0d seg=%h expected 00", m, seg);
                end
            end
        end
        blank_mask = '0;
        dp = '0;
    endtask

    task automatic test_zero_value();
        value = 16'h0012; dp = 4'b0000; load = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL zero_model m=%0d an=%b seg=%h ft=%b expected an=%b seg=%h ft=%b",
                         m, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (i >= FRAME && cur_digit() >= 2 && cur_phase() >= BLK) begin
                checks++;
                if (seg !== LEAD_ZERO_SEG) begin
                    failures++;
                    $display("FAIL zero_lead m=%0d digit=%0d seg=%h expected %h", m, cur_digit(), seg, LEAD_ZERO_SEG);
                end
            end
        end
    endtask

    task automatic test_cadence();
        int last, pulses;
        logic prev;
        last = -1; pulses = 0; prev = 1'b0;
        for (int i = 0; i < 3 * FRAME + 4; i++) begin
            step();
            if (prev === 1'b1) begin
                checks++;
                if (frame_tick !== 1'b0) begin
                    failures++;
                    $display("FAIL cadence_width m=%0d frame_tick=%b expected 0", m, frame_tick);
                end
            end
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (m - last != FRAME) begin
                        failures++;
                        $display("FAIL cadence_period interval=%0d expected %0d", m - last, FRAME);
                    end
                end
                last = m;
                pulses++;
            end
            prev = frame_tick;
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL cadence_count pulses=%0d expected 3", pulses);
        end
    endtask

    task automatic test_coincident();
        int guard;
        guard = 0;
        while ((m + 1) % FRAME != 0 && guard < 40) begin
            step();
            guard++;
        end
        value = 16'h9E07; dp = 4'b0010; load = 1'b1;
        for (int i = 0; i < FRAME + 1; i++) begin
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL coincident_model m=%0d an=%b seg=%h ft=%b expected an=%b seg=%h ft=%b",
                         m, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
            if (cur_digit() == 1 && cur_phase() >= BLK) begin
                checks++;
                if (seg !== 8'h40) begin
                    failures++;
                    $display("FAIL coincident_d1 m=%0d seg=%h expected 40", m, seg);
                end
            end
        end
        dp = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                value = 16'($urandom);
                dp    = 4'($urandom);
                load  = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            step();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_ft) begin
                failures++;
                $display("FAIL random_model m=%0d an=%b seg=%h ft=%b expected an=%b seg=%h ft=%b",
                         m, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_tearing();
        test_mask_dp();
        test_zero_value();
        test_cadence();
        test_coincident();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
